// File: rtl/voice_allocator_pkg.sv
// Shared music package: note/duration widths used by the allocator and the
// note players, plus the default voice count and small sizing helpers.
package voice_allocator_pkg;

    localparam int NOTE_W     = 6;
    localparam int DUR_W      = 6;
    localparam int NUM_VOICES = 3;

    // Note player port widths track the allocator widths so the two always agree.
    localparam int NP_NOTE_W  = NOTE_W;
    localparam int NP_DUR_W   = DUR_W;

    // Width of an age rank able to hold 0..n-1.
    function automatic int rank_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/voice_allocator_pick.sv
// Voice selection: lowest-index free voice, or (when stealing is enabled and
// every voice is busy) the voice holding the oldest age rank.
module voice_pick #(
    parameter int NUM_VOICES = 3,
    parameter int RANK_W     = 2,
    parameter bit STEAL      = 1'b0
) (
    input  logic [NUM_VOICES-1:0]        busy,
    input  logic [NUM_VOICES*RANK_W-1:0] rank,
    output logic [NUM_VOICES-1:0]        pick,
    output logic                         pick_valid
);

    logic found_free_s;

    // One-hot choice: first clear busy bit wins, else the oldest rank if stealing.
    always_comb begin
        pick         = '0;
        pick_valid   = 1'b0;
        found_free_s = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!busy[i] && !found_free_s) begin
                pick[i]      = 1'b1;
                found_free_s = 1'b1;
            end else begin
                found_free_s = found_free_s;
            end
        end
        if (found_free_s) begin
            pick_valid = 1'b1;
        end else if (STEAL) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (rank[i*RANK_W +: RANK_W] == RANK_W'(NUM_VOICES - 1)) begin
                    pick[i] = 1'b1;
                end else begin
                    pick[i] = 1'b0;
                end
            end
            pick_valid = 1'b1;
        end else begin
            pick_valid = 1'b0;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: hands incoming note requests to free note players, tracks
// per-voice occupancy and age, and optionally steals the oldest voice.
module voice_allocator #(
    parameter int NUM_VOICES = voice_allocator_pkg::NUM_VOICES,
    parameter int NOTE_W     = voice_allocator_pkg::NOTE_W,
    parameter int DUR_W      = voice_allocator_pkg::DUR_W,
    parameter bit STEAL      = 1'b0,
    localparam int CNT_W     = $clog2(NUM_VOICES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        play,
    input  logic                        flush,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [NOTE_W-1:0]           req_note,
    input  logic [DUR_W-1:0]            req_duration,
    input  logic [NUM_VOICES-1:0]       voice_done,
    output logic [NUM_VOICES-1:0]       voice_load,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*DUR_W-1:0] voice_duration,
    output logic [NUM_VOICES-1:0]       voice_busy,
    output logic [CNT_W-1:0]            active_count,
    output logic                        all_idle
);

    import voice_allocator_pkg::*;

    localparam int RANK_W = rank_width(NUM_VOICES);

    logic [NUM_VOICES-1:0]        busy_q, busy_d;
    logic [NUM_VOICES-1:0]        load_q, load_d;
    logic [NUM_VOICES*NOTE_W-1:0] note_q, note_d;
    logic [NUM_VOICES*DUR_W-1:0]  dur_q, dur_d;
    logic [NUM_VOICES*RANK_W-1:0] rank_q, rank_d;

    logic [NUM_VOICES-1:0] pick_s;
    logic                  pick_valid_s;
    logic                  accept_s;
    logic [RANK_W-1:0]     sel_rank_s;
    logic [CNT_W-1:0]      count_s;

    // Ready depends only on registered occupancy plus the control inputs;
    // holding it low while reset is asserted keeps requests out during reset.
    assign req_ready = reset & play & ~flush & ((~&busy_q) | STEAL);
    assign accept_s  = req_valid & req_ready & pick_valid_s;

    voice_pick #(
        .NUM_VOICES (NUM_VOICES),
        .RANK_W     (RANK_W),
        .STEAL      (STEAL)
    ) u_pick (
        .busy       (busy_q),
        .rank       (rank_q),
        .pick       (pick_s),
        .pick_valid (pick_valid_s)
    );

    // Next state: done clears busy (ignored on idle voices), flush clears all,
    // an accepted request loads the picked voice and makes it the newest.
    always_comb begin
        busy_d     = busy_q & ~voice_done;
        load_d     = '0;
        note_d     = note_q;
        dur_d      = dur_q;
        rank_d     = rank_q;
        sel_rank_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (pick_s[i]) begin
                sel_rank_s = rank_q[i*RANK_W +: RANK_W];
            end else begin
                sel_rank_s = sel_rank_s;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (accept_s) begin
            busy_d = busy_d | pick_s;
            load_d = pick_s;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (pick_s[i]) begin
                    note_d[i*NOTE_W +: NOTE_W] = req_note;
                    dur_d[i*DUR_W +: DUR_W]    = req_duration;
                    rank_d[i*RANK_W +: RANK_W] = '0;
                end else if (rank_q[i*RANK_W +: RANK_W] < sel_rank_s) begin
                    rank_d[i*RANK_W +: RANK_W] = rank_q[i*RANK_W +: RANK_W] + RANK_W'(1);
                end else begin
                    rank_d[i*RANK_W +: RANK_W] = rank_q[i*RANK_W +: RANK_W];
                end
            end
        end else begin
            busy_d = busy_d;
        end
    end

    // State registers; reset leaves every voice idle with ranks in index order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            load_q <= '0;
            note_q <= '0;
            dur_q  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i*RANK_W +: RANK_W] <= RANK_W'(i);
            end
        end else begin
            busy_q <= busy_d;
            load_q <= load_d;
            note_q <= note_d;
            dur_q  <= dur_d;
            rank_q <= rank_d;
        end
    end

    // Occupancy count derived from the registered busy vector.
    always_comb begin
        count_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            count_s = count_s + CNT_W'(busy_q[i]);
        end
    end

    assign voice_busy     = busy_q;
    assign voice_load     = load_q;
    assign voice_note     = note_q;
    assign voice_duration = dur_q;
    assign active_count   = count_s;
    assign all_idle       = ~|busy_q;

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, giving the number of note players served (range 2..8).
REQ-002 SHALL have parameter NOTE_W, default 6, giving the note code width.
REQ-003 SHALL have parameter DUR_W, default 6, giving the duration width in beats.
REQ-004 SHALL have parameter STEAL, default 0; 1 means that when every voice is busy, the oldest voice is stolen instead of stalling.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port play, input, 1; when low, no new requests are accepted.
REQ-008 SHALL have port flush, input, 1, a synchronous pulse that frees all voices (song change/reset_player).
REQ-009 SHALL have port req_valid, input, 1; the request carries a note to allocate.
REQ-010 SHALL have port req_ready, output, 1; the allocator accepts the request this cycle.
REQ-011 SHALL have ports req_note (input, NOTE_W) and req_duration (input, DUR_W).
REQ-012 SHALL have port voice_done, input, NUM_VOICES; these are per-voice one-cycle done pulses from the note players.
REQ-013 SHALL have port voice_load, output, NUM_VOICES; this is a one-hot, one-cycle load_new_note pulse per voice.
REQ-014 SHALL have ports voice_note (output, NUM_VOICES*NOTE_W) and voice_duration (output, NUM_VOICES*DUR_W), holding per-voice registered values, with voice i in slice i.
REQ-015 SHALL have port voice_busy, output, NUM_VOICES, giving per-voice occupancy.
REQ-016 SHALL have port active_count, output, clog2(NUM_VOICES+1), equal to the popcount of voice_busy.
REQ-017 SHALL have port all_idle, output, 1, high when voice_busy is all zero.

Function
REQ-018 SHALL drive req_ready = play & ~flush & (any voice_busy bit clear | STEAL), combinationally from registered state only.
REQ-019 SHALL accept a request on the cycle req_valid & req_ready; req_note and req_duration are sampled on that edge.
REQ-020 SHALL select the lowest-index non-busy voice; the free set comes from registered voice_busy only.
REQ-021 SHALL, with STEAL=1 and all voices busy, select the busy voice with the highest age rank.
REQ-022 SHALL, on the accept edge, update the selected voice's note and duration, set its busy bit, and assert its voice_load bit for exactly the following cycle, so that data is valid with the pulse.
REQ-023 SHALL keep an age rank per voice (0 = newest); on a load of voice v, rank[v] becomes 0 and every voice with rank < old rank[v] increments; the ranks remain a permutation of 0..NUM_VOICES-1.
REQ-024 SHALL clear busy[i] on the edge after voice_done[i]; voice_done on a non-busy voice SHALL be ignored.
REQ-025 SHALL let the load win when voice_done[i] and a steal load of voice i coincide: busy[i] stays 1.
REQ-026 SHALL accept back-to-back requests at one per cycle while free voices remain.
REQ-027 SHALL respond to flush by clearing all busy bits on the next edge, issuing no load, and retaining voice_note, voice_duration and the ranks, so that the output does not pop.
REQ-028 SHALL, while play is low, continue to process voice_done and hold all other state.

Reset
REQ-029 SHALL set, on reset assertion and independent of clk: voice_busy=0, voice_load=0, voice_note=0, voice_duration=0, active_count=0, all_idle=1, rank[i]=i.
REQ-030 SHALL keep req_ready at 0 during reset, and reset mid-operation SHALL discard any load in progress.

Structure
REQ-031 SHALL place NOTE_W, DUR_W and the default NUM_VOICES in the shared music package, alongside the note_player widths.
REQ-032 SHALL implement the selection (lowest-free / oldest-busy, one-hot output plus valid) as sub-module voice_pick.

Verification
REQ-033 SHALL cover, with STEAL=0 and idle, requests (10,4),(20,4),(30,4) back-to-back: voice_load 001,010,100 on successive cycles, busy 111, req_ready 0, active_count 3.
REQ-034 SHALL cover, with busy 111, voice_done=010 followed by request (40,2): busy becomes 101 and then 111, with voice_load=010 and voice 1 note 40.
REQ-035 SHALL cover, with busy 011, voice_done=001 and request (7,1) in the same cycle: the request goes to voice 2 and busy becomes 110.
REQ-036 SHALL cover STEAL=1 with loads in order 0,1,2 followed by requests (50,3) and (51,3): voice 0 and then voice 1 are stolen, and req_ready stays 1.
REQ-037 SHALL cover flush with busy 111: busy 000 the next cycle, no voice_load, and notes unchanged.
REQ-038 SHALL cover play=0 with req_valid=1: no load is issued, and voice_done still clears busy; reset asserted mid-stream sets all outputs to their reset values immediately.
